// File: rtl/mul_emitter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_fmt_pkg : state codes, ASCII byte constants and range helper for mul_emitter
// Rev 1.0
// ---------------------------------------------------------------------------
package mul_fmt_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CONV   = 3'd1;
  localparam state_t ST_PREFIX = 3'd2;
  localparam state_t ST_DIG_A  = 3'd3;
  localparam state_t ST_COMMA  = 3'd4;
  localparam state_t ST_DIG_B  = 3'd5;
  localparam state_t ST_CLOSE  = 3'd6;

  localparam logic [7:0] CH_M     = 8'h6D;
  localparam logic [7:0] CH_U     = 8'h75;
  localparam logic [7:0] CH_L     = 8'h6C;
  localparam logic [7:0] CH_OPEN  = 8'h28;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_CLOSE = 8'h29;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  // Largest operand that fits in the given number of decimal digits.
  function automatic int unsigned max_operand(input int unsigned digits);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_emitter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_emitter_if : operand-in / byte-out handshake bundle for mul_emitter
// Rev 1.0
// ---------------------------------------------------------------------------
interface mul_emitter_if #(
  parameter int OP_W = 10
);
  logic            op_valid;
  logic            op_ready;
  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            busy;
  logic            range_err;

  modport slave (
    input  op_valid, op_a, op_b, tx_ready,
    output op_ready, tx_data, tx_valid, busy, range_err
  );

  modport master (
    output op_valid, op_a, op_b, tx_ready,
    input  op_ready, tx_data, tx_valid, busy, range_err
  );
endinterface
`default_nettype wire

// File: rtl/mul_emitter_bin2bcd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bin2bcd_serial : shift-and-add-3 binary to BCD, one bit per clock
// Rev 1.0
// ---------------------------------------------------------------------------
module bin2bcd_serial #(
  parameter int OP_W       = 10,
  parameter int MAX_DIGITS = 3
) (
  input  wire                       clk,
  input  wire                       rst_n,
  input  wire                       start_i,
  input  wire [OP_W-1:0]            bin_i,
  output logic                      done_o,
  output logic [4*MAX_DIGITS-1:0]   bcd_o
);
  localparam int BCD_W = 4 * MAX_DIGITS;
  localparam int CNT_W = $clog2(OP_W + 1);

  logic [OP_W-1:0]  sr_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             unused_ovf;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Top BCD bit only carries out for operands beyond the legal decimal range.
  assign unused_ovf = adj[BCD_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start_i) begin
      sr_q   <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= CNT_W'(OP_W);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      bcd_q  <= {adj[BCD_W-2:0], sr_q[OP_W-1]};
      sr_q   <= {sr_q[OP_W-2:0], 1'b0};
      cnt_q  <= cnt_q - 1'b1;
      done_q <= (cnt_q == CNT_W'(1));
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;
endmodule
`default_nettype wire

// File: rtl/mul_emitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_emitter : formats operand pairs as the ASCII string "mul(A,B)"
// Rev 1.0
// ---------------------------------------------------------------------------
module mul_emitter
  import mul_fmt_pkg::*;
#(
  parameter int OP_W       = 10,
  parameter int MAX_DIGITS = 3
) (
  input wire           clk,
  input wire           rst_n,
  mul_emitter_if.slave bus
);
  localparam int          BCD_W   = 4 * MAX_DIGITS;
  localparam int          IDX_W   = (MAX_DIGITS > 4) ? $clog2(MAX_DIGITS) : 2;
  localparam int unsigned MAX_VAL = max_operand(MAX_DIGITS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             range_err_q, range_err_d;
  logic             accept, legal, start, tx_valid, xfer;
  logic             done_a, done_b;
  logic [BCD_W-1:0] bcd_a, bcd_b;
  logic [IDX_W-1:0] lead_a, lead_b;
  logic [3:0]       nib;
  logic [7:0]       tx_byte;

  function automatic logic [IDX_W-1:0] lead_idx(input logic [BCD_W-1:0] bcd);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign accept   = bus.op_valid && (state_q == ST_IDLE);
  assign legal    = (32'(bus.op_a) <= MAX_VAL) && (32'(bus.op_b) <= MAX_VAL);
  assign start    = accept && legal;
  assign tx_valid = (state_q != ST_IDLE) && (state_q != ST_CONV);
  assign xfer     = tx_valid && bus.tx_ready;
  assign lead_a   = lead_idx(bcd_a);
  assign lead_b   = lead_idx(bcd_b);

  // The converters' shift registers are the captured copies of the operands.
  bin2bcd_serial #(.OP_W(OP_W), .MAX_DIGITS(MAX_DIGITS)) u_bcd_a (
    .clk(clk), .rst_n(rst_n), .start_i(start), .bin_i(bus.op_a),
    .done_o(done_a), .bcd_o(bcd_a)
  );

  bin2bcd_serial #(.OP_W(OP_W), .MAX_DIGITS(MAX_DIGITS)) u_bcd_b (
    .clk(clk), .rst_n(rst_n), .start_i(start), .bin_i(bus.op_b),
    .done_o(done_b), .bcd_o(bcd_b)
  );

  always_comb begin
    tx_byte = 8'h00;
    nib     = 4'd0;
    case (state_q)
      ST_PREFIX: begin
        case (idx_q[1:0])
          2'd0:    tx_byte = CH_M;
          2'd1:    tx_byte = CH_U;
          2'd2:    tx_byte = CH_L;
          default: tx_byte = CH_OPEN;
        endcase
      end
      ST_DIG_A: begin
        nib     = bcd_a[{idx_q, 2'b00} +: 4];
        tx_byte = CH_ZERO + {4'd0, nib};
      end
      ST_COMMA: tx_byte = CH_COMMA;
      ST_DIG_B: begin
        nib     = bcd_b[{idx_q, 2'b00} +: 4];
        tx_byte = CH_ZERO + {4'd0, nib};
      end
      ST_CLOSE: tx_byte = CH_CLOSE;
      default:  tx_byte = 8'h00;
    endcase
  end

  // idx_q walks the prefix upward, then each operand's digits downward.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    range_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (legal) state_d     = ST_CONV;
          else       range_err_d = 1'b1;
        end
      end
      ST_CONV: begin
        if (done_a && done_b) begin
          state_d = ST_PREFIX;
          idx_d   = '0;
        end
      end
      ST_PREFIX: begin
        if (xfer) begin
          if (idx_q == IDX_W'(3)) begin
            state_d = ST_DIG_A;
            idx_d   = lead_a;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DIG_A: begin
        if (xfer) begin
          if (idx_q == '0) state_d = ST_COMMA;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      ST_COMMA: begin
        if (xfer) begin
          state_d = ST_DIG_B;
          idx_d   = lead_b;
        end
      end
      ST_DIG_B: begin
        if (xfer) begin
          if (idx_q == '0) state_d = ST_CLOSE;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      ST_CLOSE: begin
        if (xfer) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      range_err_q <= range_err_d;
    end
  end

  assign bus.op_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_data   = tx_byte;
  assign bus.range_err = range_err_q;
endmodule
`default_nettype wire

// File: tb/tb_mul_emitter.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mul_emitter : directed and random streams checked against formatted text
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mul_emitter;
  localparam int OP_W       = 10;
  localparam int MAX_DIGITS = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_emitter_if #(.OP_W(OP_W)) bus ();

  mul_emitter #(.OP_W(OP_W), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int         checks   = 0;
  int         failures = 0;
  longint     cyc      = 0;
  logic [7:0] rx_q[$];
  longint     rx_cyc[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Bytes are recorded at the falling edge ahead of the rising edge that moves them.
  always @(negedge clk) begin
    if (prev_stall) chk("stall_hold", {bus.tx_valid, bus.tx_data}, {1'b1, prev_data});
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      rx_q.push_back(bus.tx_data);
      rx_cyc.push_back(cyc);
    end
    prev_stall = rst_n && bus.tx_valid && !bus.tx_ready;
    prev_data  = bus.tx_data;
  end

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      default: return ($urandom % 3) != 0;
    endcase
  endfunction

  // Independent parser for the character protocol: returns A*B or -1 if malformed.
  function automatic longint parse_product(input logic [7:0] q[$]);
    string  pre;
    int     i;
    longint a, b;
    pre = "mul(";
    if (q.size() < 8) return -1;
    for (i = 0; i < 4; i++) if (q[i] != pre[i]) return -1;
    a = 0;
    while (i < q.size() && q[i] >= 8'h30 && q[i] <= 8'h39) begin
      a = a * 10 + longint'(q[i] - 8'h30);
      i++;
    end
    if (i >= q.size() || q[i] != 8'h2C) return -1;
    i++;
    b = 0;
    while (i < q.size() && q[i] >= 8'h30 && q[i] <= 8'h39) begin
      b = b * 10 + longint'(q[i] - 8'h30);
      i++;
    end
    if (i != q.size() - 1 || q[i] != 8'h29) return -1;
    return a * b;
  endfunction

  task automatic run_pair(input int a, input int b, input int mode);
    int    k;
    int    lat;
    bit    seen;
    string exp;
    rx_q.delete();
    rx_cyc.delete();
    chk("op_ready_idle", bus.op_ready, 1);
    bus.op_a     = OP_W'(a);
    bus.op_b     = OP_W'(b);
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.op_a     = OP_W'($urandom);
    bus.op_b     = OP_W'($urandom);
    chk("busy_after_accept", bus.busy, 1);
    chk("op_ready_in_flight", bus.op_ready, 0);
    k = 0; lat = 0; seen = 0;
    while (bus.busy && k < 400) begin
      bus.tx_ready = ready_for(mode, k);
      @(posedge clk); #1;
      k++;
      if (!seen && bus.tx_valid) begin
        seen = 1;
        lat  = k;
      end
    end
    bus.tx_ready = 1'b1;
    chk("stream_timeout", k < 400, 1);
    chk("latency", lat, OP_W + 1);
    chk("op_ready_after_close", bus.op_ready, 1);
    chk("tx_valid_after_close", bus.tx_valid, 0);
    exp = $sformatf("mul(%0d,%0d)", a, b);
    chk("length", rx_q.size(), exp.len());
    for (int i = 0; i < exp.len() && i < rx_q.size(); i++)
      chk($sformatf("byte%0d", i), rx_q[i], exp[i]);
    chk("product", parse_product(rx_q), longint'(a) * longint'(b));
    if (mode == 0 && rx_cyc.size() > 0)
      chk("consecutive", rx_cyc[rx_cyc.size()-1] - rx_cyc[0], rx_cyc.size() - 1);
  endtask

  task automatic run_illegal(input int a, input int b);
    int errs, txv, nrdy;
    rx_q.delete();
    bus.op_a     = OP_W'(a);
    bus.op_b     = OP_W'(b);
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    chk("range_err_next_cycle", bus.range_err, 1);
    errs = 0; txv = 0; nrdy = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.range_err) errs++;
      if (bus.tx_valid)  txv++;
      if (!bus.op_ready) nrdy++;
      @(posedge clk); #1;
    end
    chk("range_err_pulses", errs, 1);
    chk("range_no_tx", txv, 0);
    chk("range_ready_drops", nrdy, 0);
    chk("range_no_bytes", rx_q.size(), 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_op_ready"},  bus.op_ready, 1);
    chk({tag, "_tx_valid"},  bus.tx_valid, 0);
    chk({tag, "_tx_data"},   bus.tx_data, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_range_err"}, bus.range_err, 0);
  endtask

  initial begin
    int k;
    bus.op_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.tx_ready = 1'b1;
    #12;
    reset_checks("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_pair(2, 4, 0);
    run_pair(0, 999, 0);
    run_pair(123, 45, 1);
    run_illegal(1000, 5);
    run_illegal(5, 1023);
    run_pair(7, 8, 0);

    // Abandon a string after its prefix with an asynchronous reset.
    rx_q.delete();
    bus.op_a = OP_W'(321); bus.op_b = OP_W'(654); bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    k = 0;
    while (rx_q.size() < 4 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("prefix_timeout", k < 100, 1);
    chk("tx_valid_before_reset", bus.tx_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("tx_valid_async_drop", bus.tx_valid, 0);
    @(negedge clk);
    reset_checks("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    reset_checks("post_reset");
    run_pair(10, 100, 0);

    for (int n = 0; n < 50; n++)
      run_pair(int'($urandom_range(0, 999)), int'($urandom_range(0, 999)), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
